// File: rtl/rca_acc_pkg.sv
// rca_acc_pkg: shared types and constants for the ripple-carry result accumulator.
//   rca_acc_state_t     : two-state FSM encoding (ACCUM, HOLD)
//   acc_width()         : lossless accumulator width for a block of COUNT results
//   COUNT_MIN/COUNT_MAX : legal range of results per block
package rca_acc_pkg;

    localparam int unsigned COUNT_MIN = 2;
    localparam int unsigned COUNT_MAX = 256;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } rca_acc_state_t;

    // Each result is width+1 bits; summing count of them needs $clog2(count) extra bits.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned count);
        return width + 1 + $clog2(count);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   i_a, i_b : operand bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/rca_acc_adder.sv
// rca_acc_adder: combinational WIDTH-bit ripple adder built from full_adder cells,
// carry-in tied to 0.
//   i_a, i_b : unsigned operands
//   o_sum    : i_a + i_b, truncated to WIDTH bits
// The accumulator is sized so the sum never carries out of the MSB, so the top bit
// is a plain XOR and no carry-out is produced. WIDTH must be at least 2.
module rca_acc_adder #(
    parameter int unsigned WIDTH = 13
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    // Per-stage scalar carries avoid a self-referencing carry vector.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
        logic cin;
        logic cout;

        if (i == 0) begin : g_lsb
            assign cin = 1'b0;
        end else begin : g_mid
            assign cin = g_bit[i-1].cout;
        end

        full_adder u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (cin),
            .o_sum  (o_sum[i]),
            .o_cout (cout)
        );
    end

    assign o_sum[WIDTH-1] = i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ g_bit[WIDTH-2].cout;

endmodule

// File: rtl/rca_result_accum.sv
// rca_result_accum: sums fixed blocks of COUNT adder results into a lossless
// accumulator and presents each block total over a valid/ready handshake.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid, o_ready  : upstream result handshake
//   i_result          : WIDTH+1-bit adder result (carry-out in MSB)
//   o_acc_valid       : block total available
//   i_acc_ready       : downstream accepts the total
//   o_acc             : ACC_WIDTH-bit block total (running sum while accumulating)
//   o_peak            : largest result in the block, only with RCA_ACC_PEAK_EN defined
// Optional feature macro: RCA_ACC_PEAK_EN (adds o_peak and its register).
// All outputs are decoded from registers only; no input-to-output path.
module rca_result_accum
    import rca_acc_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned COUNT = 16,
    localparam int unsigned ACC_WIDTH = acc_width(WIDTH, COUNT)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH:0]       i_result,
    output logic                 o_acc_valid,
    input  logic                 i_acc_ready,
    output logic [ACC_WIDTH-1:0] o_acc
`ifdef RCA_ACC_PEAK_EN
    ,
    output logic [WIDTH:0]       o_peak
`endif
);

    if (COUNT < COUNT_MIN || COUNT > COUNT_MAX) begin : g_count_range_err
        $error("rca_result_accum: COUNT out of legal range");
    end

    // Counter only needs to reach COUNT-1; the last beat returns it to 0.
    localparam int unsigned   CNT_W    = $clog2(COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    rca_acc_state_t       state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] addend;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 beat;
    logic                 out_hs;
    logic                 last_beat;

    assign beat      = i_valid && (state_q == ACCUM);
    assign out_hs    = i_acc_ready && (state_q == HOLD);
    assign last_beat = (cnt_q == CNT_LAST);
    assign addend    = {{(ACC_WIDTH - WIDTH - 1){1'b0}}, i_result};

    rca_acc_adder #(
        .WIDTH (ACC_WIDTH)
    ) u_adder (
        .i_a   (acc_q),
        .i_b   (addend),
        .o_sum (acc_sum)
    );

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (beat && last_beat) state_d = HOLD;
            HOLD:  if (i_acc_ready)       state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_ready     = (state_q == ACCUM);
        o_acc_valid = (state_q == HOLD);
    end

    // Datapath next state
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (out_hs) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (beat) begin
            acc_d = acc_sum;
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_acc = acc_q;

`ifdef RCA_ACC_PEAK_EN
    logic [WIDTH:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (out_hs) begin
            peak_d = '0;
        end else if (beat && (i_result > peak_q)) begin
            peak_d = i_result;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign o_peak = peak_q;
`endif

endmodule

// File: tb/tb_rca_result_accum.sv
// Self-checking bench for rca_result_accum with WIDTH=10, COUNT=4 (ACC_WIDTH=13).
// The reference model keeps the accepted results of the current block in a queue;
// the expected total and peak are the sum and maximum of that queue.
module tb_rca_result_accum;

    localparam int unsigned WIDTH     = 10;
    localparam int unsigned COUNT     = 4;
    localparam int unsigned ACC_WIDTH = 13;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid;
    logic                 ready;
    logic [WIDTH:0]       result;
    logic                 acc_valid;
    logic                 acc_ready;
    logic [ACC_WIDTH-1:0] acc;
`ifdef RCA_ACC_PEAK_EN
    logic [WIDTH:0]       peak;
`endif

    int checks   = 0;
    int failures = 0;

    int unsigned mq[$];
    bit          m_hold = 1'b0;

    rca_result_accum #(
        .WIDTH (WIDTH),
        .COUNT (COUNT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_result    (result),
        .o_acc_valid (acc_valid),
        .i_acc_ready (acc_ready),
        .o_acc       (acc)
`ifdef RCA_ACC_PEAK_EN
        ,
        .o_peak      (peak)
`endif
    );

    always #5 clk = ~clk;

    function automatic int unsigned m_sum();
        int unsigned s = 0;
        foreach (mq[i]) s += mq[i];
        return s;
    endfunction

    function automatic int unsigned m_peak();
        int unsigned p = 0;
        foreach (mq[i]) if (mq[i] > p) p = mq[i];
        return p;
    endfunction

    // Advance one clock: update the model from the inputs seen at this edge,
    // then sample point is 1 time unit after the edge.
    task automatic tick();
        if (rst === 1'b1) begin
            mq.delete();
            m_hold = 1'b0;
        end else if (!m_hold && valid === 1'b1) begin
            mq.push_back(int'(result));
            if (mq.size() == COUNT) m_hold = 1'b1;
        end else if (m_hold && acc_ready === 1'b1) begin
            mq.delete();
            m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned v);
        valid  = 1'b1;
        result = (WIDTH+1)'(v);
        tick();
        valid  = 1'b0;
    endtask

    task automatic handshake();
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; acc_ready = 1'b0; result = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", ready); end
        checks++; if (acc_valid !== 1'b0) begin failures++; $display("FAIL reset_acc_valid: got %0b want 0", acc_valid); end
        checks++; if (acc !== '0) begin failures++; $display("FAIL reset_acc: got %0d want 0", acc); end
`ifdef RCA_ACC_PEAK_EN
        checks++; if (peak !== '0) begin failures++; $display("FAIL reset_peak: got %0d want 0", peak); end
`endif
    endtask

    task automatic test_max_values();
        int vcount = 0;
        acc_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(2047);
        checks++; if (acc_valid !== 1'b1) begin failures++; $display("FAIL max_valid_rise: got %0b want 1", acc_valid); end
        checks++; if (acc !== 13'd8188) begin failures++; $display("FAIL max_acc: got %0d want 8188", acc); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL max_ready_low: got %0b want 0", ready); end
        if (acc_valid === 1'b1) vcount++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (acc_valid === 1'b1) vcount++;
        end
        checks++; if (vcount != 1) begin failures++; $display("FAIL max_valid_cycles: got %0d want 1", vcount); end
        acc_ready = 1'b0;
    endtask

    task automatic test_gapped();
        int unsigned pat[4] = '{5, 0, 1000, 3};
        acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b0; result = 11'd2047;
            tick();
            tick();
            send(pat[i]);
        end
        result = 11'd2047;
        tick();
        checks++; if (acc_valid !== 1'b1) begin failures++; $display("FAIL gap_valid: got %0b want 1", acc_valid); end
        checks++; if (acc !== 13'd1008) begin failures++; $display("FAIL gap_acc: got %0d want 1008", acc); end
        handshake();
        checks++; if (acc_valid !== 1'b0 || ready !== 1'b1) begin
            failures++; $display("FAIL gap_release: got valid=%0b ready=%0b want 0/1", acc_valid, ready);
        end
    endtask

    task automatic test_backpressure();
        int unsigned total;
        acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom_range(0, 2047));
        total = m_sum();
        valid = 1'b1; result = 11'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (acc !== ACC_WIDTH'(total) || ready !== 1'b0 || acc_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got acc=%0d ready=%0b valid=%0b want %0d/0/1",
                         i, acc, ready, acc_valid, total);
            end
        end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        valid = 1'b0;
        checks++; if (acc_valid !== 1'b1 || acc !== 13'd28) begin
            failures++; $display("FAIL bp_next_block: got valid=%0b acc=%0d want 1/28", acc_valid, acc);
        end
        handshake();
    endtask

    task automatic test_reset_mid_block();
        send(100);
        send(100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(1);
        checks++; if (acc_valid !== 1'b1 || acc !== 13'd4) begin
            failures++; $display("FAIL rst_mid_acc: got valid=%0b acc=%0d want 1/4", acc_valid, acc);
        end
        handshake();
    endtask

`ifdef RCA_ACC_PEAK_EN
    task automatic test_peak();
        send(12); send(900); send(4); send(899);
        checks++; if (peak !== 11'd900) begin failures++; $display("FAIL peak_val: got %0d want 900", peak); end
        checks++; if (acc !== 13'd1815) begin failures++; $display("FAIL peak_acc: got %0d want 1815", acc); end
        handshake();
        checks++; if (peak !== '0) begin failures++; $display("FAIL peak_clear: got %0d want 0", peak); end
        send(3); send(1); send(2); send(1);
        checks++; if (peak !== 11'd3) begin failures++; $display("FAIL peak_next: got %0d want 3", peak); end
        handshake();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid     = ($urandom_range(0, 3) != 0);
            result    = (WIDTH+1)'($urandom_range(0, 2047));
            acc_ready = ($urandom_range(0, 2) == 0);
            tick();
            checks++; if (ready !== !m_hold || acc_valid !== m_hold) begin
                failures++;
                $display("FAIL rand_flags[%0d]: got ready=%0b valid=%0b want %0b/%0b",
                         i, ready, acc_valid, !m_hold, m_hold);
            end
            if (m_hold) begin
                checks++; if (acc !== ACC_WIDTH'(m_sum())) begin
                    failures++; $display("FAIL rand_acc[%0d]: got %0d want %0d", i, acc, m_sum());
                end
`ifdef RCA_ACC_PEAK_EN
                checks++; if (peak !== (WIDTH+1)'(m_peak())) begin
                    failures++; $display("FAIL rand_peak[%0d]: got %0d want %0d", i, peak, m_peak());
                end
`endif
            end
        end
        valid = 1'b0;
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max_values();
        test_gapped();
        test_backpressure();
        test_reset_mid_block();
`ifdef RCA_ACC_PEAK_EN
        test_peak();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
